fetch_sequencer: RTL and testbench

//  Owns the program counter and load path of the nRISC instruction memory (256 x 18-bit, async read).

---
 rtl/fetch_sequencer_pkg.sv | 15 +
 rtl/fetch_sequencer_pc_unit.sv | 43 ++++
 rtl/fetch_sequencer.sv | 148 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// rtl/fetch_sequencer_pkg.sv - shared widths and FSM state encoding for the nRISC fetch sequencer
package fetch_sequencer_pkg;

    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_INSTR_W = 18;

    // Encodings are visible on state_o, so the values are fixed
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_HALT = 2'd3
    } state_t;

endpackage

// File: rtl/fetch_sequencer_pc_unit.sv
// rtl/fetch_sequencer_pc_unit.sv - program counter with clear/load/increment and end-of-program compare
module fetch_sequencer_pc_unit
    import fetch_sequencer_pkg::*;
#(
    parameter int AW = DEF_ADDR_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clear,
    input  logic          i_load,
    input  logic          i_inc,
    input  logic [AW-1:0] i_target,
    input  logic [AW:0]   i_prog_len,
    output logic [AW-1:0] o_pc,
    output logic          o_is_last,
    output logic          o_target_ok
);

    localparam logic [AW-1:0] ONE   = 1;
    localparam logic [AW:0]   ONE_X = 1;

    logic [AW-1:0] r_pc;
    logic [AW:0]   w_pc_ext;

    assign w_pc_ext = {1'b0, r_pc};

    // pc register: clear beats redirect beats increment; otherwise hold
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_pc <= '0;
        end else if (i_load) begin
            r_pc <= i_target;
        end else if (i_inc) begin
            r_pc <= r_pc + ONE;
        end
    end

    // Compares are done one bit wider so prog_len = 256 needs no special case
    assign o_is_last   = (w_pc_ext + ONE_X) == i_prog_len;
    assign o_target_ok = {1'b0, i_target} < i_prog_len;
    assign o_pc        = r_pc;

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - program loader, pc sequencing and instruction register for the nRISC core
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_start,
    input  logic               load_valid,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               load_last,
    output logic               load_ready,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_waddr,
    output logic [INSTR_W-1:0] mem_wdata,
    input  logic               start,
    output logic [ADDR_W-1:0]  pc,
    input  logic [INSTR_W-1:0] instr_in,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic               halt_req,
    output logic [ADDR_W:0]    prog_len,
    output logic [1:0]         state_o,
    output logic               bad_target
);

    localparam logic [ADDR_W-1:0] A_ONE = 1;
    localparam logic [ADDR_W:0]   L_ONE = 1;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_waddr;
    logic [INSTR_W-1:0]  r_instr;
    logic                r_valid;
    logic                r_bad;
    logic [ADDR_W:0]     r_prog_len;

    logic                w_run;
    logic                w_idle_or_halt;
    logic                w_halt;
    logic                w_branch;
    logic                w_adv;
    logic                w_go;
    logic                w_ldst;
    logic                w_is_last;
    logic                w_target_ok;
    logic [ADDR_W-1:0]   w_pc;

    // RUN-state priority decode: halt > branch > stall > advance
    assign w_run          = (r_state == S_RUN);
    assign w_idle_or_halt = (r_state == S_IDLE) || (r_state == S_HALT);
    assign w_halt         = w_run & halt_req;
    assign w_branch       = w_run & ~halt_req & branch_taken;
    assign w_adv          = w_run & ~halt_req & ~branch_taken & ~stall;
    // load_start is honoured everywhere except RUN and always beats start
    assign w_ldst         = load_start & ~w_run;
    assign w_go           = start & ~load_start & w_idle_or_halt;

    fetch_sequencer_pc_unit #(
        .AW (ADDR_W)
    ) u_pc (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (w_go | w_ldst),
        .i_load      (w_branch & w_target_ok),
        .i_inc       (w_adv & ~w_is_last),
        .i_target    (branch_target),
        .i_prog_len  (r_prog_len),
        .o_pc        (w_pc),
        .o_is_last   (w_is_last),
        .o_target_ok (w_target_ok)
    );

    // Main FSM: owns the load counter, program length, instruction register and flags
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_waddr    <= '0;
            r_instr    <= '0;
            r_valid    <= 1'b0;
            r_bad      <= 1'b0;
            r_prog_len <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_HALT: begin
                    r_valid <= 1'b0;
                    if (load_start) begin
                        r_state    <= S_LOAD;
                        r_waddr    <= '0;
                        r_prog_len <= '0;
                        r_bad      <= 1'b0;
                    end else if (start) begin
                        r_bad   <= 1'b0;
                        r_state <= (r_prog_len != '0) ? S_RUN : S_HALT;
                    end
                end
                S_LOAD: begin
                    if (load_start) begin
                        r_waddr <= '0;
                    end else if (load_valid) begin
                        r_waddr <= r_waddr + A_ONE;
                        if (load_last || (r_waddr == '1)) begin
                            r_state    <= S_IDLE;
                            r_prog_len <= {1'b0, r_waddr} + L_ONE;
                        end
                    end
                end
                S_RUN: begin
                    if (w_halt) begin
                        r_state <= S_HALT;
                        r_valid <= 1'b0;
                    end else if (w_branch) begin
                        // Word fetched this cycle is squashed either way
                        r_valid <= 1'b0;
                        if (!w_target_ok) begin
                            r_state <= S_HALT;
                            r_bad   <= 1'b1;
                        end
                    end else if (w_adv) begin
                        r_instr <= instr_in;
                        r_valid <= 1'b1;
                        // Last word is still delivered; pc holds so it never wraps
                        if (w_is_last) begin
                            r_state <= S_HALT;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign load_ready  = (r_state == S_LOAD);
    assign mem_we      = load_valid & load_ready;
    assign mem_waddr   = r_waddr;
    assign mem_wdata   = load_data;
    assign pc          = w_pc;
    assign instr_out   = r_instr;
    assign instr_valid = r_valid;
    assign prog_len    = r_prog_len;
    assign state_o     = r_state;
    assign bad_target  = r_bad;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed scoreboard bench for fetch_sequencer
module tb_fetch_sequencer;

    localparam int AW = 8;
    localparam int IW = 18;

    logic          clk;
    logic          reset;
    logic          load_start;
    logic          load_valid;
    logic [IW-1:0] load_data;
    logic          load_last;
    logic          load_ready;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [IW-1:0] mem_wdata;
    logic          start;
    logic [AW-1:0] pc;
    logic [IW-1:0] instr_in;
    logic [IW-1:0] instr_out;
    logic          instr_valid;
    logic          stall;
    logic          branch_taken;
    logic [AW-1:0] branch_target;
    logic          halt_req;
    logic [AW:0]   prog_len;
    logic [1:0]    state_o;
    logic          bad_target;

    fetch_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .load_start    (load_start),
        .load_valid    (load_valid),
        .load_data     (load_data),
        .load_last     (load_last),
        .load_ready    (load_ready),
        .mem_we        (mem_we),
        .mem_waddr     (mem_waddr),
        .mem_wdata     (mem_wdata),
        .start         (start),
        .pc            (pc),
        .instr_in      (instr_in),
        .instr_out     (instr_out),
        .instr_valid   (instr_valid),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halt_req      (halt_req),
        .prog_len      (prog_len),
        .state_o       (state_o),
        .bad_target    (bad_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model: sync write port, async read
    logic [IW-1:0] mem [256];
    always @(posedge clk) if (mem_we) mem[mem_waddr] <= mem_wdata;
    assign instr_in = mem[pc];

    logic [IW-1:0] prog [256];
    logic [IW-1:0] sb [$];
    logic [IW-1:0] exp_word;
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard drain: the decoder consumes instr_out whenever it is valid and not stalled
    always @(negedge clk) begin
        if (!reset && instr_valid && !stall) begin
            total++;
            assert (sb.size() > 0) else begin
                bad++;
                $error("FAIL sb_underflow observed=%0h expected=none", instr_out);
            end
            if (sb.size() > 0) begin
                exp_word = sb.pop_front();
                check("instr_out_sb", instr_out, exp_word);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) sb.push_back(prog[i]);
    endtask

    task automatic load_prog(input int n, input bit use_last, input int gap_at);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                load_valid = 1'b0;
                tick();
            end
            load_valid = 1'b1;
            load_data  = prog[i];
            load_last  = use_last && (i == n - 1);
            tick();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_pc(input string tag, input int n);
        for (int k = 0; k < 300; k++) begin
            if (pc == AW'(n)) break;
            tick();
        end
        check(tag, pc, n);
    endtask

    task automatic wait_halt(input string tag);
        for (int k = 0; k < 700; k++) begin
            if (state_o == 2'd3 && !instr_valid) break;
            tick();
        end
        check(tag, {state_o, instr_valid}, {2'd3, 1'b0});
        check({tag, "_sb_empty"}, sb.size(), 0);
    endtask

    initial begin
        reset = 1'b1; load_start = 0; load_valid = 0; load_data = '0; load_last = 0;
        start = 0; stall = 0; branch_taken = 0; branch_target = '0; halt_req = 0;
        for (int i = 0; i < 256; i++) prog[i] = IW'($urandom);
        tick();
        tick();
        reset = 1'b0;
        check("rst_state", state_o, 0);
        check("rst_pc", pc, 0);
        check("rst_instr_out", instr_out, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_prog_len", prog_len, 0);
        check("rst_bad", bad_target, 0);
        check("rst_load_ready", load_ready, 0);
        check("rst_waddr", mem_waddr, 0);

        // 30-word program with a host gap, then full run
        load_prog(30, 1'b1, 5);
        check("load_state", state_o, 0);
        check("load_prog_len", prog_len, 30);
        check("load_ready_off", load_ready, 0);
        push_range(0, 29);
        pulse_start();
        check("run_state", state_o, 2);
        check("run_pc0", pc, 0);
        check("run_first_valid", instr_valid, 0);
        load_valid = 1'b1;
        #1;
        check("run_no_we", mem_we, 0);
        load_valid = 1'b0;
        tick();
        check("run_latency_valid", instr_valid, 1);
        check("run_latency_word", instr_out, prog[0]);
        wait_halt("run1_halt");

        // Stall three cycles at pc 5
        push_range(0, 29);
        pulse_start();
        wait_pc("stall_reach", 5);
        stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            tick();
            check("stall_pc", pc, 5);
            check("stall_instr", instr_out, prog[4]);
            check("stall_valid", instr_valid, 1);
        end
        stall = 1'b0;
        tick();
        check("stall_resume_pc", pc, 6);
        check("stall_resume_instr", instr_out, prog[5]);
        wait_halt("stall_halt");

        // Backward branch 27 -> 22 with one bubble
        push_range(0, 26);
        push_range(22, 29);
        pulse_start();
        wait_pc("br_reach", 27);
        branch_taken = 1'b1;
        branch_target = 8'd22;
        tick();
        branch_taken = 1'b0;
        check("br_bubble", instr_valid, 0);
        check("br_pc", pc, 22);
        tick();
        check("br_valid", instr_valid, 1);
        check("br_word", instr_out, prog[22]);
        wait_halt("br_halt");

        // Branch beyond program end
        push_range(0, 9);
        pulse_start();
        wait_pc("bad_reach", 10);
        branch_taken = 1'b1;
        branch_target = 8'd40;
        tick();
        branch_taken = 1'b0;
        check("bad_state", state_o, 3);
        check("bad_flag", bad_target, 1);
        check("bad_valid", instr_valid, 0);
        push_range(0, 29);
        pulse_start();
        check("bad_clear", bad_target, 0);
        check("bad_restart_pc", pc, 0);
        check("bad_restart_state", state_o, 2);
        wait_halt("bad_halt");

        // halt_req and branch_taken together
        push_range(0, 7);
        pulse_start();
        wait_pc("hb_reach", 8);
        halt_req = 1'b1;
        branch_taken = 1'b1;
        branch_target = 8'd3;
        tick();
        halt_req = 1'b0;
        branch_taken = 1'b0;
        check("hb_state", state_o, 3);
        check("hb_pc", pc, 8);
        check("hb_valid", instr_valid, 0);
        tick();
        check("hb_pc_frozen", pc, 8);
        check("hb_sb_empty", sb.size(), 0);

        // Reset in the middle of a load, then start with no program
        load_prog(10, 1'b0, -1);
        check("midload_state", state_o, 1);
        check("midload_waddr", mem_waddr, 10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_state", state_o, 0);
        check("abort_prog_len", prog_len, 0);
        check("abort_waddr", mem_waddr, 0);
        check("abort_load_ready", load_ready, 0);
        pulse_start();
        check("empty_start_state", state_o, 3);
        check("empty_start_valid", instr_valid, 0);
        check("empty_start_pc", pc, 0);

        // Full 256-word memory without load_last; pc must stop at 255
        load_prog(256, 1'b0, -1);
        check("full_state", state_o, 0);
        check("full_prog_len", prog_len, 256);
        push_range(0, 255);
        pulse_start();
        wait_halt("full_halt");
        check("full_pc_no_wrap", pc, 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
